// File: rtl/conv_window_gen.sv
// conv_window_gen: raster-scans an image memory and emits 3x3 windows (nine 20-bit pixels) with one pixel of padding.
// Build option: CONV_WINGEN_EDGE_REPLICATE_EN clamps edge coordinates instead of padding with zeros.
`default_nettype none

module conv_window_gen #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [19:0]       mem_data,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [179:0]      o_data,
    output logic              o_busy,
    output logic              o_done
);

    localparam int XW = $clog2(IMG_W + 1);
    localparam int YW = $clog2(IMG_H + 1);
    localparam logic [XW-1:0] c_X_LAST = XW'(IMG_W - 1);
    localparam logic [XW-1:0] c_W      = XW'(IMG_W);
    localparam logic [YW-1:0] c_Y_LAST = YW'(IMG_H - 1);
    localparam logic [YW:0]   c_H_P1   = (YW+1)'(IMG_H);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EMIT  = 2'd2,
        S_DONE  = 2'd3
    } t_state;

    t_state            r_state;
    logic [1:0]        r_cyc;
    logic [XW-1:0]     r_x;
    logic [XW-1:0]     r_xf;
    logic [YW-1:0]     r_y;
    logic              r_row_first;
    logic              r_shift_pend;
    logic              r_rd_d;
    logic              r_mem_rd;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_valid;
    logic              r_busy;
    logic              r_done;
    logic [2:0][19:0]  r_col_l;
    logic [2:0][19:0]  r_col_m;
    logic [2:0][19:0]  r_col_r;

    // Read request for the FETCH cycle that starts on the next edge.
    logic              w_iss;
    logic [1:0]        w_ic;
    logic [YW-1:0]     w_iy;
    logic [XW-1:0]     w_ixf;
    logic [YW:0]       w_row_p1;
    logic              w_row_ok;
    logic              w_col_ok;
    logic [YW-1:0]     w_row;
    logic [XW-1:0]     w_col;
    logic              w_rd_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;

    always_comb begin
        w_iss = 1'b0;
        w_ic  = 2'd0;
        w_iy  = r_y;
        w_ixf = r_xf;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_iss = 1'b1;
                    w_iy  = '0;
                    w_ixf = '0;
                end
            end
            S_FETCH: begin
                case (r_cyc)
                    2'd0: begin
                        w_iss = 1'b1;
                        w_ic  = 2'd1;
                    end
                    2'd1: begin
                        w_iss = 1'b1;
                        w_ic  = 2'd2;
                    end
                    2'd3: begin
                        if (r_row_first) begin
                            w_iss = 1'b1;
                            w_ixf = XW'(1);
                        end
                    end
                    default: ;
                endcase
            end
            S_EMIT: begin
                if (o_ready) begin
                    if (r_x != c_X_LAST) begin
                        w_iss = 1'b1;
                        w_ixf = r_x + XW'(2);
                    end else if (r_y != c_Y_LAST) begin
                        w_iss = 1'b1;
                        w_iy  = r_y + YW'(1);
                        w_ixf = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    // w_row_p1 is the requested row plus one, so row -1 maps to 0 without signed arithmetic.
    always_comb begin
        w_row_p1 = {1'b0, w_iy} + {{(YW-1){1'b0}}, w_ic};
        w_row_ok = (w_row_p1 != '0) && (w_row_p1 <= c_H_P1);
        w_col_ok = (w_ixf != c_W);
        if (w_row_ok)
            w_row = YW'(w_row_p1 - (YW+1)'(1));
        else if (w_row_p1 == '0)
            w_row = '0;
        else
            w_row = c_Y_LAST;
        w_col      = w_col_ok ? w_ixf : c_X_LAST;
        w_addr_nxt = ADDR_W'(w_row) * ADDR_W'(IMG_W) + ADDR_W'(w_col);
`ifdef CONV_WINGEN_EDGE_REPLICATE_EN
        w_rd_nxt   = w_iss;
`else
        w_rd_nxt   = w_iss && w_row_ok && w_col_ok;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cyc        <= 2'd0;
            r_x          <= '0;
            r_xf         <= '0;
            r_y          <= '0;
            r_row_first  <= 1'b0;
            r_shift_pend <= 1'b0;
            r_rd_d       <= 1'b0;
            r_mem_rd     <= 1'b0;
            r_mem_addr   <= '0;
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_col_l      <= '0;
            r_col_m      <= '0;
            r_col_r      <= '0;
        end else begin
            r_mem_rd <= w_rd_nxt;
            if (w_rd_nxt)
                r_mem_addr <= w_addr_nxt;
            r_rd_d <= r_mem_rd;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state     <= S_FETCH;
                        r_cyc       <= 2'd0;
                        r_x         <= '0;
                        r_y         <= '0;
                        r_xf        <= '0;
                        r_row_first <= 1'b1;
                        r_col_l     <= '0;
                        r_busy      <= 1'b1;
                    end
                end
                S_FETCH: begin
                    r_cyc <= r_cyc + 2'd1;
                    // Data for the read issued in cycle c arrives in cycle c+1; masked reads load zero.
                    if (r_cyc != 2'd0)
                        r_col_r[r_cyc - 2'd1] <= r_rd_d ? mem_data : 20'd0;
                    if (r_cyc == 2'd0 && r_shift_pend) begin
                        r_col_m      <= r_col_r;
                        r_shift_pend <= 1'b0;
`ifdef CONV_WINGEN_EDGE_REPLICATE_EN
                        r_col_l      <= r_col_r;
`endif
                    end
                    if (r_cyc == 2'd3) begin
                        if (r_row_first) begin
                            r_row_first  <= 1'b0;
                            r_shift_pend <= 1'b1;
                            r_xf         <= XW'(1);
                        end else begin
                            r_state <= S_EMIT;
                            r_valid <= 1'b1;
                        end
                    end
                end
                S_EMIT: begin
                    if (o_ready) begin
                        r_valid <= 1'b0;
                        r_cyc   <= 2'd0;
                        if (r_x != c_X_LAST) begin
                            r_col_l <= r_col_m;
                            r_col_m <= r_col_r;
                            r_x     <= r_x + XW'(1);
                            r_xf    <= r_x + XW'(2);
                            r_state <= S_FETCH;
                        end else if (r_y != c_Y_LAST) begin
                            r_x         <= '0;
                            r_y         <= r_y + YW'(1);
                            r_xf        <= '0;
                            r_row_first <= 1'b1;
                            r_col_l     <= '0;
                            r_state     <= S_FETCH;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_rd   = r_mem_rd;
    assign mem_addr = r_mem_addr;
    assign o_valid  = r_valid;
    assign o_busy   = r_busy;
    assign o_done   = r_done;

    for (genvar gy = 0; gy < 3; gy++) begin : g_row
        assign o_data[(3*gy+0)*20 +: 20] = r_col_l[gy];
        assign o_data[(3*gy+1)*20 +: 20] = r_col_m[gy];
        assign o_data[(3*gy+2)*20 +: 20] = r_col_r[gy];
    end

endmodule

`default_nettype wire

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: drives conv_window_gen from a memory model and compares every window,
// handshake gap and frame total against an independent coordinate-based reference.
`default_nettype none

module tb_conv_window_gen;

    localparam int W  = 64;
    localparam int H  = 64;
    localparam int AW = 12;
    localparam int CW = 200;

    logic          clk;
    logic          reset;
    logic          i_start;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [19:0]   mem_data;
    logic          o_valid;
    logic          ready;
    logic [179:0]  o_data;
    logic          o_busy;
    logic          o_done;

    conv_window_gen #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .i_start  (i_start),
        .mem_rd   (mem_rd),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .o_valid  (o_valid),
        .o_ready  (ready),
        .o_data   (o_data),
        .o_busy   (o_busy),
        .o_done   (o_done)
    );

    logic [19:0] mem [0:W*H-1];
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    int exp_y, exp_x, start_edge, prev_edge, stalls, total_stalls;
    int n_acc, n_reads, n_done;
    bit fixed_en;

`ifdef CONV_WINGEN_EDGE_REPLICATE_EN
    localparam int EXP_READS = H * (W + 1) * 3;
`else
    localparam int EXP_READS = W * (3 * H - 2);
`endif
    localparam int BASE_LEN = H * (9 + (W - 1) * 5) + 1;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read memory; undefined cycles return noise.
    always @(posedge clk) mem_data <= mem_rd ? mem[mem_addr] : 20'($urandom);

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [179:0] model_win(input int cy, input int cx);
        logic [179:0] w;
        int py, px;
        w = '0;
        for (int dy = 0; dy < 3; dy++) begin
            for (int dx = 0; dx < 3; dx++) begin
                py = cy - 1 + dy;
                px = cx - 1 + dx;
`ifdef CONV_WINGEN_EDGE_REPLICATE_EN
                if (py < 0) py = 0;
                if (py > H - 1) py = H - 1;
                if (px < 0) px = 0;
                if (px > W - 1) px = W - 1;
                w[(3*dy+dx)*20 +: 20] = mem[py*W+px];
`else
                if (py >= 0 && py < H && px >= 0 && px < W)
                    w[(3*dy+dx)*20 +: 20] = mem[py*W+px];
`endif
            end
        end
        return w;
    endfunction

    function automatic logic [179:0] pack9(input int s0, input int s1, input int s2,
                                           input int s3, input int s4, input int s5,
                                           input int s6, input int s7, input int s8);
        logic [179:0] w;
        w = {20'(s8), 20'(s7), 20'(s6), 20'(s5), 20'(s4), 20'(s3), 20'(s2), 20'(s1), 20'(s0)};
        return w;
    endfunction

    always @(negedge clk) begin
        int row, col;
        bit ok;
        if (mem_rd) begin
            n_reads++;
            row = int'(mem_addr) / W;
            col = int'(mem_addr) % W;
            ok  = (int'(mem_addr) < W*H) && (row >= exp_y - 1) && (row <= exp_y + 1)
                  && (col >= exp_x) && (col <= exp_x + 1);
            chk("rd_addr", CW'(ok), CW'(1));
        end
        if (o_valid) begin
            chk("rd_in_emit", CW'(mem_rd), CW'(0));
            chk("win", CW'(o_data), CW'(model_win(exp_y, exp_x)));
            if (fixed_en && exp_y == 5 && exp_x == 7)
                chk("slot4_5_7", CW'(o_data[4*20 +: 20]), CW'(327));
            if (ready) begin
                chk("gap", CW'(cyc + 1 - prev_edge), CW'((exp_x == 0 ? 9 : 5) + stalls));
                if (fixed_en) begin
`ifdef CONV_WINGEN_EDGE_REPLICATE_EN
                    if (exp_y == 0 && exp_x == 0)
                        chk("win_0_0", CW'(o_data), CW'(pack9(0, 0, 1, 0, 0, 1, 64, 64, 65)));
                    if (exp_y == 63 && exp_x == 63)
                        chk("win_63_63", CW'(o_data),
                            CW'(pack9(4030, 4031, 4031, 4094, 4095, 4095, 4094, 4095, 4095)));
`else
                    if (exp_y == 0 && exp_x == 0)
                        chk("win_0_0", CW'(o_data), CW'(pack9(0, 0, 0, 0, 0, 1, 0, 64, 65)));
                    if (exp_y == 63 && exp_x == 63)
                        chk("win_63_63", CW'(o_data),
                            CW'(pack9(4030, 4031, 0, 4094, 4095, 0, 0, 0, 0)));
`endif
                    if (exp_y == 1 && exp_x == 1)
                        chk("win_1_1", CW'(o_data),
                            CW'(pack9(0, 1, 2, 64, 65, 66, 128, 129, 130)));
                end
                prev_edge = cyc + 1;
                stalls    = 0;
                n_acc++;
                exp_x++;
                if (exp_x == W) begin
                    exp_x = 0;
                    exp_y++;
                end
            end else begin
                stalls++;
                total_stalls++;
            end
        end
        if (o_done) begin
            n_done++;
            chk("frame_len", CW'(cyc + 1 - start_edge), CW'(BASE_LEN + total_stalls));
            chk("n_accepts", CW'(n_acc), CW'(W*H));
            chk("n_reads", CW'(n_reads), CW'(EXP_READS));
        end
    end

    task automatic start_frame();
        @(posedge clk); #1;
        i_start      = 1'b1;
        start_edge   = cyc + 1;
        prev_edge    = cyc + 1;
        exp_y        = 0;
        exp_x        = 0;
        stalls       = 0;
        total_stalls = 0;
        n_acc        = 0;
        n_reads      = 0;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    // mode 0: ready held high; 1: random ready; 2: ten stalled cycles at window (5,7).
    task automatic run_frame(input int mode, input int pulse_at);
        bit seen;
        int k;
        int done0;
        seen  = 1'b0;
        k     = 0;
        done0 = n_done;
        for (int i = 0; i < 60000; i++) begin
            @(posedge clk); #1;
            i_start = (i == pulse_at);
            case (mode)
                1: ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (exp_y == 5 && exp_x == 7) begin
                        if (o_valid) k++;
                        ready = (k > 10);
                    end else begin
                        ready = 1'b1;
                    end
                end
                default: ready = 1'b1;
            endcase
            @(negedge clk);
            if (o_done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("frame_timeout", CW'(0), CW'(1));
        i_start = 1'b0;
        ready   = 1'b1;
        @(negedge clk);
        chk("busy_after_done", CW'(o_busy), CW'(0));
        repeat (3) @(negedge clk);
        chk("done_once", CW'(n_done - done0), CW'(1));
    endtask

    initial begin
        n_done   = 0;
        fixed_en = 1'b0;
        exp_y    = 0;
        exp_x    = 0;
        reset    = 1'b1;
        i_start  = 1'b0;
        ready    = 1'b1;
        for (int a = 0; a < W*H; a++) mem[a] = 20'(a);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", CW'({o_valid, o_busy, o_done, mem_rd, mem_addr, o_data}), CW'(0));
        reset = 1'b0;

        // Frame A: ramp image, backpressure at (5,7).
        fixed_en = 1'b1;
        start_frame();
        run_frame(2, -1);
        fixed_en = 1'b0;

        // Frame B: random image, random backpressure.
        for (int a = 0; a < W*H; a++) mem[a] = 20'($urandom);
        start_frame();
        run_frame(1, -1);

        // Abort inside the fetch of window (2,3).
        for (int a = 0; a < W*H; a++) mem[a] = 20'(a);
        start_frame();
        for (int i = 0; i < 2000 && cyc < start_edge + 670; i++) begin
            @(posedge clk); #1;
        end
        chk("abort_pos", CW'(exp_y * W + exp_x), CW'(2 * W + 3));
        chk("busy_pre_abort", CW'(o_busy), CW'(1));
        #2;
        reset = 1'b1;
        #1;
        chk("abort_outs", CW'({o_valid, o_busy, o_done, mem_rd, mem_addr, o_data}), CW'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_after_abort", CW'({o_busy, o_valid, mem_rd, o_done}), CW'(0));

        // Frame C: restart after abort, with a stray start pulse mid-frame.
        fixed_en = 1'b1;
        start_frame();
        run_frame(0, 50);
        fixed_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
